// File: rtl/isa_pkg.sv
// 9-bit ISA table shared by the encoder and decode: op enum, field prefixes, encode and legality helpers.
// Pure combinational functions; no latency, no flow control.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_CMP = 5'h00,
        OP_MOV = 5'h01,
        OP_ADD = 5'h08,
        OP_SUB = 5'h09,
        OP_AND = 5'h0A,
        OP_OR  = 5'h0B,
        OP_XOR = 5'h0C,
        OP_SHL = 5'h0D,
        OP_SHR = 5'h0E,
        OP_ADC = 5'h0F,
        OP_JG  = 5'h10,
        OP_JGE = 5'h11,
        OP_JMP = 5'h12,
        OP_INC = 5'h14,
        OP_DEC = 5'h15,
        OP_CLR = 5'h17,
        OP_LOL = 5'h18,
        OP_NOT = 5'h19,
        OP_LSR = 5'h1A,
        OP_LDR = 5'h1B,
        OP_STR = 5'h1C,
        OP_LDI = 5'h1D,
        OP_STI = 5'h1E
    } enc_op_e;

    // Hole in the INC/DEC/CLR group: its f=10 slot collides with the LOL prefix.
    localparam logic [4:0] OP_IDC_F10 = 5'h16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FULL
    } enc_state_e;

    localparam logic [1:0] PFX_CMPMOV = 2'b00;
    localparam logic [1:0] PFX_ALU2   = 2'b01;
    localparam logic [3:0] PFX_JCOND  = 4'b1000;
    localparam logic [4:0] PFX_JMP    = 5'b10010;
    localparam logic [3:0] PFX_IDC    = 4'b1010;
    localparam logic [5:0] PFX_LOL    = 6'b101010;
    localparam logic [4:0] PFX_NOTLSR = 5'b10110;
    localparam logic [5:0] PFX_LDR    = 6'b101110;
    localparam logic [5:0] PFX_STR    = 6'b101111;
    localparam logic [4:0] PFX_LDISTI = 5'b11000;

    function automatic logic [8:0] encode_instr(input logic [4:0] op,
                                                input logic [2:0] ra,
                                                input logic [2:0] rb,
                                                input logic [3:0] imm);
        logic [8:0] w;
        w = '0;
        case (op)
            OP_CMP:                  w = {PFX_CMPMOV, 1'b0, ra, rb};
            OP_MOV:                  w = {PFX_CMPMOV, 1'b1, ra, rb};
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_ADC:
                                     w = {PFX_ALU2, op[2:0], ra[1:0], rb[1:0]};
            OP_JG, OP_JGE:           w = {PFX_JCOND, op == OP_JGE, imm};
            OP_JMP:                  w = {PFX_JMP, imm};
            // f is the low two op bits, so the op numbering carries the subfield
            OP_INC, OP_DEC, OP_CLR, OP_IDC_F10:
                                     w = {PFX_IDC, op[1:0], ra};
            OP_LOL:                  w = {PFX_LOL, rb};
            OP_NOT, OP_LSR:          w = {PFX_NOTLSR, op == OP_LSR, ra};
            OP_LDR:                  w = {PFX_LDR, rb};
            OP_STR:                  w = {PFX_STR, ra};
            OP_LDI, OP_STI:          w = {PFX_LDISTI, op == OP_STI, imm[2:0]};
            default:                 w = '0;
        endcase
        return w;
    endfunction

    function automatic logic op_illegal(input logic [4:0] op,
                                        input logic [2:0] ra,
                                        input logic [2:0] rb,
                                        input logic [3:0] imm);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_ADC:
                                     bad = ra[2] | rb[2];
            OP_LDI, OP_STI:          bad = imm[3];
            OP_IDC_F10:              bad = 1'b1;
            OP_CMP, OP_MOV, OP_JG, OP_JGE, OP_JMP,
            OP_INC, OP_DEC, OP_CLR, OP_LOL, OP_NOT,
            OP_LSR, OP_LDR, OP_STR:  bad = 1'b0;
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Encodes op requests into 9-bit words and streams them to instr memory (ENCODER_CHECK_EN adds sticky err).
// Latency 1: handshake in cycle N gives mem_we with the encoded word in N+1; one word per cycle.
// Backpressure: req_ready is high only in RUN; DONE/FULL/IDLE stall until the next start.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int PROG_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [2:0]        req_ra,
    input  logic [2:0]        req_rb,
    input  logic [3:0]        req_imm,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [8:0]        mem_wdata,
    output logic              full,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(PROG_DEPTH);

    enc_state_e        state_q;
    enc_state_e        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              hs;
    logic              at_last;
    logic              base_ok;

    // start overrides everything, including a request presented in the same cycle
    assign hs      = req_valid & req_ready & ~start;
    assign at_last = (ptr_q == LAST_ADDR);
    // An out-of-range base would point past the program area; treat it as already full.
    assign base_ok = ({1'b0, base_addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = base_ok ? ST_RUN : ST_FULL;
        end else if (hs) begin
            if (req_last) begin
                state_d = ST_DONE;
            end else if (at_last) begin
                state_d = ST_FULL;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            full      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= hs;
            if (start) begin
                ptr_q <= base_addr;
                full  <= ~base_ok;
                done  <= 1'b0;
            end else if (hs) begin
                mem_addr  <= ptr_q;
                mem_wdata <= encode_instr(req_op, req_ra, req_rb, req_imm);
                // pointer parks on the last address instead of wrapping
                if (!at_last) begin
                    ptr_q <= ptr_q + 1'b1;
                end else begin
                    full <= 1'b1;
                end
                if (req_last) begin
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef ENCODER_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (hs && op_illegal(req_op, req_ra, req_rb, req_imm)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and random stimulus for instr_encoder against a cycle-level behavioural model of the spec.
module tb_instr_encoder;
    import isa_pkg::*;

    localparam int DEPTH = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_op;
    logic [2:0] req_ra;
    logic [2:0] req_rb;
    logic [3:0] req_imm;
    logic       req_last;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [8:0] mem_wdata;
    logic       full;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // model state: what the outputs should read just after the next edge
    bit m_run, m_done, m_full, m_err, m_we;
    int m_ptr, m_addr, m_wdata;

    instr_encoder #(.ADDR_W(8), .PROG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ra(req_ra), .req_rb(req_rb), .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .full(full), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word value built from the field layout as plain arithmetic (bit 8 = 256).
    function automatic int ref_word(input logic [4:0] op, input int a, input int b, input int imm);
        int w;
        case (op)
            OP_CMP:  w = a * 8 + b;
            OP_MOV:  w = 64 + a * 8 + b;
            OP_ADD:  w = 128 + 0 * 16 + (a % 4) * 4 + (b % 4);
            OP_SUB:  w = 128 + 1 * 16 + (a % 4) * 4 + (b % 4);
            OP_AND:  w = 128 + 2 * 16 + (a % 4) * 4 + (b % 4);
            OP_OR:   w = 128 + 3 * 16 + (a % 4) * 4 + (b % 4);
            OP_XOR:  w = 128 + 4 * 16 + (a % 4) * 4 + (b % 4);
            OP_SHL:  w = 128 + 5 * 16 + (a % 4) * 4 + (b % 4);
            OP_SHR:  w = 128 + 6 * 16 + (a % 4) * 4 + (b % 4);
            OP_ADC:  w = 128 + 7 * 16 + (a % 4) * 4 + (b % 4);
            OP_JG:   w = 256 + imm;
            OP_JGE:  w = 272 + imm;
            OP_JMP:  w = 288 + imm;
            OP_INC:  w = 320 + a;
            OP_DEC:  w = 328 + a;
            5'h16:   w = 336 + a;
            OP_CLR:  w = 344 + a;
            OP_LOL:  w = 336 + b;
            OP_NOT:  w = 352 + a;
            OP_LSR:  w = 360 + a;
            OP_LDR:  w = 368 + b;
            OP_STR:  w = 376 + a;
            OP_LDI:  w = 384 + imm % 8;
            OP_STI:  w = 392 + imm % 8;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit ref_bad(input logic [4:0] op, input int a, input int b, input int imm);
        bit bad;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADC:
                bad = (a > 3) || (b > 3);
            OP_LDI, OP_STI: bad = (imm > 7);
            OP_CMP, OP_MOV, OP_JG, OP_JGE, OP_JMP, OP_INC, OP_DEC, OP_CLR,
            OP_LOL, OP_NOT, OP_LSR, OP_LDR, OP_STR: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    task automatic cycle();
        if (!rst_n) begin
            m_run = 0; m_ptr = 0; m_done = 0; m_full = 0; m_err = 0;
            m_we = 0; m_addr = 0; m_wdata = 0;
        end else if (start) begin
            m_run  = (int'(base_addr) < DEPTH);
            m_full = !(int'(base_addr) < DEPTH);
            m_ptr  = int'(base_addr);
            m_done = 0; m_err = 0; m_we = 0;
        end else if (req_valid && m_run) begin
            m_we    = 1;
            m_addr  = m_ptr;
            m_wdata = ref_word(req_op, int'(req_ra), int'(req_rb), int'(req_imm));
`ifdef ENCODER_CHECK_EN
            if (ref_bad(req_op, int'(req_ra), int'(req_rb), int'(req_imm))) m_err = 1;
`endif
            if (req_last) begin
                m_done = 1;
                m_run  = 0;
            end
            if (m_ptr == DEPTH - 1) begin
                m_full = 1;
                m_run  = 0;
            end else begin
                m_ptr++;
            end
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        #1;
        chk("req_ready", req_ready, m_run);
        chk("mem_we", mem_we, m_we);
        if (m_we) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("full", full, m_full);
        chk("done", done, m_done);
        chk("err", err, m_err);
    endtask

    task automatic set_req(input logic [4:0] op, input int a, input int b, input int imm, input bit last);
        req_valid = 1'b1;
        req_op    = op;
        req_ra    = 3'(a);
        req_rb    = 3'(b);
        req_imm   = 4'(imm);
        req_last  = last;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        bit exp_err;
`ifdef ENCODER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0;
        req_op = '0; req_ra = '0; req_rb = '0; req_imm = '0; req_last = 1'b0;

        // reset state
        cycle();
        cycle();
        check_reset_vals("rst");
        rst_n = 1'b1;

        // IDLE ignores requests
        set_req(OP_MOV, 1, 2, 0, 0);
        cycle();
        chk("idle_we", mem_we, 0);

        // 1: MOV a=3 b=5 at base 0x10
        req_valid = 1'b0; start = 1'b1; base_addr = 8'h10;
        cycle();
        start = 1'b0;
        set_req(OP_MOV, 3, 5, 0, 0);
        cycle();
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 8'h10);
        chk("t1_wdata", mem_wdata, 9'b001011101);

        // 2: back-to-back JMP imm=9, LDI imm=4 (last)
        set_req(OP_JMP, 0, 0, 9, 0);
        cycle();
        chk("t2_jmp", mem_wdata, 9'b100101001);
        chk("t2_jmp_addr", mem_addr, 8'h11);
        set_req(OP_LDI, 0, 0, 4, 1);
        cycle();
        chk("t2_ldi", mem_wdata, 9'b110000100);
        chk("t2_ldi_addr", mem_addr, 8'h12);
        chk("t2_done", done, 1);
        chk("t2_ready", req_ready, 0);
        set_req(OP_INC, 1, 0, 0, 0);
        cycle();
        chk("t2_stall_we", mem_we, 0);

        // 3: fill the last two addresses, third request stalls
        req_valid = 1'b0; start = 1'b1; base_addr = 8'(DEPTH - 2);
        cycle();
        start = 1'b0;
        set_req(OP_ADD, 1, 2, 0, 0);
        cycle();
        set_req(OP_NOT, 4, 0, 0, 0);
        cycle();
        chk("t3_addr", mem_addr, DEPTH - 1);
        chk("t3_full", full, 1);
        set_req(OP_LSR, 5, 0, 0, 0);
        cycle();
        chk("t3_stall_we", mem_we, 0);
        chk("t3_ready", req_ready, 0);

        // 4: start with a valid request in RUN: no accept, pointer reloads
        req_valid = 1'b0; start = 1'b1; base_addr = 8'h05;
        cycle();
        start = 1'b0;
        set_req(OP_INC, 2, 0, 0, 0);
        cycle();
        start = 1'b1; base_addr = 8'h08;
        set_req(OP_STR, 6, 0, 0, 0);
        cycle();
        chk("t4_no_we", mem_we, 0);
        start = 1'b0;
        cycle();
        chk("t4_newbase", mem_addr, 8'h08);

        // 5: LDI with imm[3] set, err sticky until next start
        set_req(OP_LDI, 0, 0, 4'hC, 0);
        cycle();
        chk("t5_wdata", mem_wdata, 9'b110000100);
        chk("t5_err", err, exp_err);
        req_valid = 1'b0;
        cycle();
        chk("t5_err_hold", err, exp_err);
        start = 1'b1; base_addr = 8'h00;
        cycle();
        start = 1'b0;
        chk("t5_err_clr", err, 0);

        // 6: reset the cycle after a handshake drops the next write
        set_req(OP_CMP, 1, 2, 0, 0);
        cycle();
        set_req(OP_SUB, 3, 1, 0, 0);
        rst_n = 1'b0;
        cycle();
        check_reset_vals("t6");
        rst_n = 1'b1;
        req_valid = 1'b0;
        cycle();

        // full and last on the same write: both flags, DONE
        start = 1'b1; base_addr = 8'(DEPTH - 1);
        cycle();
        start = 1'b0;
        set_req(OP_CLR, 7, 0, 0, 1);
        cycle();
        chk("t7_full", full, 1);
        chk("t7_done", done, 1);
        cycle();
        chk("t7_ready", req_ready, 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            start     = ($urandom_range(0, 19) == 0);
            base_addr = 8'($urandom_range(0, DEPTH + 2));
            req_valid = ($urandom_range(0, 9) < 7);
            req_op    = 5'($urandom_range(0, 31));
            req_ra    = 3'($urandom_range(0, 7));
            req_rb    = 3'($urandom_range(0, 7));
            req_imm   = 4'($urandom_range(0, 15));
            req_last  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
